// File: rtl/snn_delay_layer_if.sv
// snn_delay_layer_if: spike, configuration and status signals of the delay layer
interface snn_delay_layer_if #(
    parameter int N_IN  = 8,
    parameter int N_OUT = 2,
    parameter int MP_W  = 6
);
    logic                    step;
    logic [N_IN-1:0]         input_spikes;
    logic                    cfg_we;
    logic [7:0]              cfg_addr;
    logic [7:0]              cfg_wdata;
    logic [N_OUT-1:0]        output_spikes;
    logic                    spike_valid;
    logic [N_OUT*MP_W-1:0]   membrane_out;
    logic                    running;
    modport master (
        output step, input_spikes, cfg_we, cfg_addr, cfg_wdata,
        input  output_spikes, spike_valid, membrane_out, running
    );
    modport slave (
        input  step, input_spikes, cfg_we, cfg_addr, cfg_wdata,
        output output_spikes, spike_valid, membrane_out, running
    );
endinterface

// File: rtl/snn_delay_layer.sv
// snn_delay_layer: LIF spiking layer with per-synapse axonal delays and byte-wide config port
module snn_delay_layer #(
    parameter int N_IN   = 8,
    parameter int N_OUT  = 2,
    parameter int W_BITS = 4,
    parameter int D_BITS = 3,
    parameter int MP_W   = 6
) (
    input logic              clk,
    input logic              rst_n,
    snn_delay_layer_if.slave bus
);
    localparam int MAXD = 2**D_BITS - 1;
    localparam int NSYN = N_IN * N_OUT;
    localparam int KW   = $clog2(NSYN);
    localparam int SW   = MP_W + W_BITS + $clog2(N_IN) + 2;
    localparam logic signed [SW-1:0] VMAX = SW'((1 << MP_W) - 1);

    logic [MP_W-1:0]   thr_q, thr_d, decay_q, decay_d;
    logic [3:0]        refp_q, refp_d;
    logic              run_q, run_d;
    logic [W_BITS-1:0] w_q [NSYN];
    logic [W_BITS-1:0] w_d [NSYN];
    logic [D_BITS-1:0] dl_q [NSYN];
    logic [D_BITS-1:0] dl_d [NSYN];
    logic [MAXD-1:0]   hist_q [N_IN];
    logic [MAXD-1:0]   hist_d [N_IN];
    logic [MP_W-1:0]   v_q [N_OUT];
    logic [MP_W-1:0]   v_d [N_OUT];
    logic [3:0]        refr_q [N_OUT];
    logic [3:0]        refr_d [N_OUT];
    logic [N_OUT-1:0]  spk_q, spk_d;
    logic              sv_q, sv_d;

    logic                 acc, clr, syn_we;
    logic [7:0]           syn_k;
    logic                 act [NSYN];
    logic signed [SW-1:0] sum_c [N_OUT];
    logic signed [SW-1:0] t_c [N_OUT];
    logic [MP_W-1:0]      clamp_c [N_OUT];
    logic [N_OUT-1:0]     fire_c;
    logic                 unused_wdata;

    assign acc          = bus.step && run_q;
    assign clr          = bus.cfg_we && bus.cfg_addr == 8'h03 && bus.cfg_wdata[1];
    assign syn_k        = bus.cfg_addr - 8'h10;
    assign syn_we       = bus.cfg_we && bus.cfg_addr >= 8'h10 && int'(syn_k) < NSYN;
    assign unused_wdata = ^bus.cfg_wdata;

    // delay 0 taps the live input, delay d taps the input from d steps ago
    always_comb begin
        for (int k = 0; k < NSYN; k++)
            act[k] = dl_q[k] == '0 ? bus.input_spikes[k % N_IN]
                                   : hist_q[k % N_IN][dl_q[k] - D_BITS'(1)];
    end

    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            sum_c[j] = '0;
            for (int i = 0; i < N_IN; i++)
                sum_c[j] = sum_c[j] + (act[j*N_IN+i]
                    ? {{(SW-W_BITS){w_q[j*N_IN+i][W_BITS-1]}}, w_q[j*N_IN+i]} : '0);
            t_c[j]     = SW'(v_q[j]) - SW'(decay_q) + sum_c[j];
            clamp_c[j] = t_c[j] < 0 ? '0 : t_c[j] > VMAX ? '1 : t_c[j][MP_W-1:0];
            fire_c[j]  = refr_q[j] == '0 && clamp_c[j] >= thr_q;
        end
    end

    always_comb begin
        thr_d   = thr_q;
        decay_d = decay_q;
        refp_d  = refp_q;
        run_d   = run_q;
        w_d     = w_q;
        dl_d    = dl_q;
        hist_d  = hist_q;
        v_d     = v_q;
        refr_d  = refr_q;
        spk_d   = spk_q;
        sv_d    = 1'b0;
        if (acc) begin
            sv_d  = 1'b1;
            spk_d = fire_c;
            for (int j = 0; j < N_OUT; j++) begin
                v_d[j]    = (refr_q[j] != '0 || fire_c[j]) ? '0 : clamp_c[j];
                refr_d[j] = refr_q[j] != '0 ? refr_q[j] - 4'd1 : fire_c[j] ? refp_q : '0;
            end
            for (int i = 0; i < N_IN; i++)
                hist_d[i] = (hist_q[i] << 1) | MAXD'(bus.input_spikes[i]);
        end
        if (bus.cfg_we) begin
            thr_d   = bus.cfg_addr == 8'h00 ? bus.cfg_wdata[MP_W-1:0] : thr_q;
            decay_d = bus.cfg_addr == 8'h01 ? bus.cfg_wdata[MP_W-1:0] : decay_q;
            refp_d  = bus.cfg_addr == 8'h02 ? bus.cfg_wdata[3:0] : refp_q;
            run_d   = bus.cfg_addr == 8'h03 ? bus.cfg_wdata[0] : run_q;
        end
        if (syn_we) begin
            w_d[syn_k[KW-1:0]]  = bus.cfg_wdata[W_BITS-1:0];
            dl_d[syn_k[KW-1:0]] = bus.cfg_wdata[W_BITS+D_BITS-1:W_BITS];
        end
        // clear wins over a coincident step but leaves configuration intact
        if (clr) begin
            hist_d = '{default: '0};
            v_d    = '{default: '0};
            refr_d = '{default: '0};
            spk_d  = '0;
            sv_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            thr_q   <= '0;
            decay_q <= '0;
            refp_q  <= '0;
            run_q   <= 1'b0;
            w_q     <= '{default: '0};
            dl_q    <= '{default: '0};
            hist_q  <= '{default: '0};
            v_q     <= '{default: '0};
            refr_q  <= '{default: '0};
            spk_q   <= '0;
            sv_q    <= 1'b0;
        end else begin
            thr_q   <= thr_d;
            decay_q <= decay_d;
            refp_q  <= refp_d;
            run_q   <= run_d;
            w_q     <= w_d;
            dl_q    <= dl_d;
            hist_q  <= hist_d;
            v_q     <= v_d;
            refr_q  <= refr_d;
            spk_q   <= spk_d;
            sv_q    <= sv_d;
        end
    end

    assign bus.output_spikes = spk_q;
    assign bus.spike_valid   = sv_q;
    assign bus.running       = run_q;
    for (genvar g = 0; g < N_OUT; g++) begin : g_mem
        assign bus.membrane_out[g*MP_W +: MP_W] = v_q[g];
    end
endmodule

// File: tb/tb_snn_delay_layer.sv
// tb_snn_delay_layer: scoreboard bench with a step-level reference model of the delay layer
module tb_snn_delay_layer;
    localparam int N_IN = 8, N_OUT = 2, MP_W = 6, MAXD = 7, NSYN = 16;
    localparam int EW = N_OUT + N_OUT * MP_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    snn_delay_layer_if #(.N_IN(N_IN), .N_OUT(N_OUT), .MP_W(MP_W)) bus ();
    snn_delay_layer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0, errors = 0;
    logic [EW-1:0] exp_q [$];
    logic [EW-1:0] mon_e;

    int   thr_m, decay_m, refp_m;
    bit   run_m;
    int   w_m [NSYN];
    int   d_m [NSYN];
    int   v_m [N_OUT];
    int   refr_m [N_OUT];
    logic [7:0] past_m [$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        thr_m = 0; decay_m = 0; refp_m = 0; run_m = 0;
        for (int k = 0; k < NSYN; k++) begin w_m[k] = 0; d_m[k] = 0; end
        for (int j = 0; j < N_OUT; j++) begin v_m[j] = 0; refr_m[j] = 0; end
        past_m.delete();
    endtask

    task automatic model_step(input logic [7:0] sp);
        logic [EW-1:0] e;
        e = '0;
        for (int j = 0; j < N_OUT; j++) begin
            int s, t, k;
            bit arrived;
            if (refr_m[j] > 0) begin
                refr_m[j]--;
                v_m[j] = 0;
            end else begin
                s = 0;
                for (int i = 0; i < N_IN; i++) begin
                    k = j * N_IN + i;
                    if (d_m[k] == 0) arrived = sp[i];
                    else if (d_m[k] <= past_m.size()) arrived = past_m[d_m[k]-1][i];
                    else arrived = 0;
                    if (arrived) s += w_m[k];
                end
                t = v_m[j] - decay_m + s;
                if (t < 0) t = 0;
                if (t > 63) t = 63;
                if (t >= thr_m) begin
                    e[j] = 1'b1;
                    v_m[j] = 0;
                    refr_m[j] = refp_m;
                end else v_m[j] = t;
            end
            e[N_OUT + j*MP_W +: MP_W] = MP_W'(v_m[j]);
        end
        exp_q.push_back(e);
        past_m.push_front(sp);
        if (past_m.size() > MAXD) void'(past_m.pop_back());
    endtask

    task automatic model_cfg(input logic [7:0] a, input logic [7:0] d);
        if (a == 8'h00) thr_m = int'(d[5:0]);
        else if (a == 8'h01) decay_m = int'(d[5:0]);
        else if (a == 8'h02) refp_m = int'(d[3:0]);
        else if (a == 8'h03) begin
            run_m = d[0];
            if (d[1]) begin
                for (int j = 0; j < N_OUT; j++) begin v_m[j] = 0; refr_m[j] = 0; end
                past_m.delete();
            end
        end else if (a >= 8'h10 && a < 8'h10 + NSYN) begin
            logic signed [3:0] ws;
            ws = d[3:0];
            w_m[a - 8'h10] = int'(ws);
            d_m[a - 8'h10] = int'(d[6:4]);
        end
    endtask

    task automatic cyc(input bit st, input logic [7:0] sp, input bit we,
                       input logic [7:0] a, input logic [7:0] d);
        bit clr;
        @(negedge clk);
        bus.step = st; bus.input_spikes = sp; bus.cfg_we = we;
        bus.cfg_addr = a; bus.cfg_wdata = d;
        if (rst_n) begin
            clr = we && a == 8'h03 && d[1];
            if (st && run_m && !clr) model_step(sp);
            if (we) model_cfg(a, d);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d); cyc(0, 8'h00, 1, a, d); endtask
    task automatic stp(input logic [7:0] sp); cyc(1, sp, 0, 8'h00, 8'h00); endtask
    task automatic idle(); cyc(0, 8'h00, 0, 8'h00, 8'h00); endtask

    task automatic fresh();
        wr(8'h03, 8'h02);
        wr(8'h00, 8'h00); wr(8'h01, 8'h00); wr(8'h02, 8'h00);
        for (int k = 0; k < NSYN; k++) wr(8'(8'h10 + k), 8'h00);
    endtask

    task automatic rand_cfg(output logic [7:0] a, output logic [7:0] d);
        int r;
        r = $urandom_range(0, 9);
        d = 8'($urandom);
        if (r == 0) begin a = 8'h00; d = {2'($urandom), 6'($urandom_range(0, 20))}; end
        else if (r == 1) begin a = 8'h01; d = {6'($urandom), 2'($urandom)}; end
        else if (r == 2) begin a = 8'h02; d = {6'($urandom), 2'($urandom)}; end
        else if (r == 3) begin
            a = 8'h03;
            d[1] = ($urandom_range(0, 9) == 0);
            d[0] = ($urandom_range(0, 7) != 0);
        end else if (r == 4) begin
            a = 8'($urandom_range(0, 3) == 0 ? 8'h04 : $urandom_range(0, 1) == 0 ? 8'h20 : 8'hFF);
        end else a = 8'(8'h10 + $urandom_range(0, NSYN - 1));
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.spike_valid) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_valid: spike_valid=1 with no accepted step, expected 0");
            end else begin
                mon_e = exp_q.pop_front();
                check("scoreboard {membrane,spikes}", int'({bus.membrane_out, bus.output_spikes}), int'(mon_e));
            end
        end
    end

    int ev_refr [8] = '{1, 2, 3, 4, 0, 0, 0, 1};

    initial begin
        logic [7:0] a, d;
        model_reset();
        bus.step = 0; bus.input_spikes = 0; bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_wdata = 0;
        for (int c = 0; c < 4; c++) cyc(c[0], 8'hFF, 0, 8'h00, 8'h00);
        check("reset_membrane", int'(bus.membrane_out), 0);
        check("reset_spikes", int'(bus.output_spikes), 0);
        check("reset_valid", int'(bus.spike_valid), 0);
        check("reset_running", int'(bus.running), 0);
        rst_n = 1'b1;
        stp(8'hFF); idle();
        check("norun_valid", int'(bus.spike_valid), 0);
        check("norun_spikes", int'(bus.output_spikes), 0);

        // delayed arrival
        fresh(); wr(8'h10, 8'h27); wr(8'h00, 8'd6); wr(8'h03, 8'h01);
        stp(8'h01); idle();
        check("delay_s1_spk", int'(bus.output_spikes[0]), 0);
        check("delay_s1_v", int'(bus.membrane_out[5:0]), 0);
        stp(8'h00); idle();
        check("delay_s2_spk", int'(bus.output_spikes[0]), 0);
        check("delay_s2_v", int'(bus.membrane_out[5:0]), 0);
        stp(8'h00); idle();
        check("delay_s3_spk", int'(bus.output_spikes[0]), 1);

        // leak and integrate, then refractory
        for (int pass = 0; pass < 2; pass++) begin
            fresh(); wr(8'h10, 8'h02); wr(8'h01, 8'd1); wr(8'h00, 8'd5);
            wr(8'h02, pass == 0 ? 8'd0 : 8'd2); wr(8'h03, 8'h01);
            for (int s = 0; s < (pass == 0 ? 5 : 8); s++) begin
                stp(8'h01); idle();
                check(pass == 0 ? "leak_v" : "refr_v", int'(bus.membrane_out[5:0]), ev_refr[s]);
                check(pass == 0 ? "leak_spk" : "refr_spk", int'(bus.output_spikes[0]), s == 4 ? 1 : 0);
            end
        end

        // saturation at both rails
        fresh(); wr(8'h00, 8'd63);
        for (int k = 0; k < 8; k++) wr(8'(8'h10 + k), 8'h08);
        wr(8'h03, 8'h01);
        for (int s = 0; s < 2; s++) begin
            stp(8'hFF); idle();
            check("sat_low_v", int'(bus.membrane_out[5:0]), 0);
        end
        for (int k = 0; k < 8; k++) wr(8'(8'h10 + k), 8'h07);
        stp(8'hFF); idle();
        check("sat_s1_v", int'(bus.membrane_out[5:0]), 56);
        check("sat_s1_spk", int'(bus.output_spikes[0]), 0);
        stp(8'hFF); idle();
        check("sat_s2_v", int'(bus.membrane_out[5:0]), 0);
        check("sat_s2_spk", int'(bus.output_spikes[0]), 1);

        // config write and clear colliding with a step
        fresh(); wr(8'h10, 8'h02); wr(8'h00, 8'd12); wr(8'h03, 8'h01);
        cyc(1, 8'h01, 1, 8'h10, 8'h07); idle();
        check("coll_old_weight_v", int'(bus.membrane_out[5:0]), 2);
        stp(8'h01); idle();
        check("coll_new_weight_v", int'(bus.membrane_out[5:0]), 9);
        stp(8'h01); idle();
        check("coll_spike", int'(bus.output_spikes[0]), 1);
        cyc(1, 8'h01, 1, 8'h03, 8'h03); idle();
        check("clear_spikes", int'(bus.output_spikes), 0);
        check("clear_membrane", int'(bus.membrane_out), 0);
        check("clear_valid", int'(bus.spike_valid), 0);
        check("clear_running", int'(bus.running), 1);
        stp(8'h01); idle();
        check("clear_restart_v", int'(bus.membrane_out[5:0]), 7);

        // randomized traffic
        fresh(); wr(8'h03, 8'h01);
        for (int it = 0; it < 3000; it++) begin
            int r;
            r = $urandom_range(0, 199);
            if (r < 100) stp(8'($urandom));
            else if (r < 130) begin rand_cfg(a, d); cyc(1, 8'($urandom), 1, a, d); end
            else if (r < 170) begin rand_cfg(a, d); wr(a, d); end
            else if (r < 175) cyc(1, 8'($urandom), 1, 8'h03, 8'h03);
            else if (r < 180) wr(8'h03, 8'h01);
            else if (r == 199) begin
                idle(); idle();
                @(negedge clk);
                rst_n = 1'b0; bus.step = 0; bus.cfg_we = 0;
                model_reset();
                @(negedge clk);
                check("midrst_running", int'(bus.running), 0);
                check("midrst_membrane", int'(bus.membrane_out), 0);
                rst_n = 1'b1;
                wr(8'h03, 8'h01);
            end else idle();
        end
        idle(); idle(); idle();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/snn_delay_layer.md
# snn_delay_layer

Parametrised single-layer leaky integrate-and-fire (LIF) spiking layer with per-synapse programmable axonal delays and register-programmed weights, threshold, leak and refractory period. It is the configurable successor to the fixed two-layer SNN core: weights and delays are loaded through a byte-wide configuration port rather than tied to pins. The network advances one time step per `step` pulse. It sits behind the TinyTapeout top level, with `ui_in` and `uio_in` muxed onto the spike and config ports.

## Interface
- `N_IN`, 8: presynaptic inputs.
- `N_OUT`, 2: LIF neurons.
- `W_BITS`, 4: signed two's-complement weight width.
- `D_BITS`, 3: delay width; max delay `MAXD = 2^D_BITS-1` steps.
- `MP_W`, 6: unsigned membrane-potential width.
- Legal ranges: `W_BITS+D_BITS<=8`, `MP_W<=8`, `N_IN*N_OUT<=240`.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset is synchronous and active-low.
- `step` in 1: one-cycle pulse; advances the network one time step.
- `input_spikes` in N_IN: spikes sampled on `step`.
- `cfg_we` in 1: config write strobe.
- `cfg_addr` in 8: config address.
- `cfg_wdata` in 8: config data.
- `output_spikes` out N_OUT: registered spikes from the last step.
- `spike_valid` out 1: one-cycle pulse after each accepted step.
- `membrane_out` out N_OUT*MP_W: potentials; neuron j occupies bits `[j*MP_W +: MP_W]`.
- `running` out 1: control bit 0.

## Operation
- Config map, written on any cycle with `cfg_we`:
  - 0x00 threshold, low `MP_W` bits.
  - 0x01 decay, low `MP_W` bits.
  - 0x02 refractory period, low 4 bits.
  - 0x03 control: bit0 run; bit1 clear, self-clearing.
  - 0x10+k synapse k = j*N_IN+i: `wdata[W_BITS-1:0]` weight, `wdata[W_BITS+D_BITS-1:W_BITS]` delay.
  - Unmapped addresses are ignored.
- History: each input i keeps shift register `hist_i[MAXD-1:0]`. On an accepted step, `hist_i <= {hist_i[MAXD-2:0], input_spikes[i]}`. This update happens after evaluation.
- Delayed spike for synapse (i,j) with delay d:
  - d=0: `input_spikes[i]`.
  - d>0: `hist_i[d-1]`.
  - An input at step n therefore reaches the neuron at step n+d.
- Neuron j evaluation on an accepted step:
  - If `refr_j>0`: `refr_j--`, v=0, no spike. History still shifts.
  - Otherwise: `sum = Σ` over active delayed synapses of `sext(weight)`. Compute `t = v - decay + sum` in signed width `MP_W+W_BITS+clog2(N_IN)+2`. Clamp to [0, 2^MP_W-1].
  - If the clamped value is >= threshold: spike, v=0, `refr_j = refractory`. Else v = clamped value.
  - A threshold of 0 spikes on every non-refractory step.
- Accepted step: `step && running`. A step while not running is ignored: no state change and no `spike_valid`.
- Clear (control bit1):
  - Zeroes v, refr, hist, `output_spikes` and `spike_valid` next cycle.
  - Config registers are kept. The run bit takes the written value.
  - Clear has priority over a step in the same cycle.
- Reset values:
  - All config registers 0, including weights, delays and run.
  - All state 0.
  - `output_spikes=0`, `spike_valid=0`, `membrane_out=0`, `running=0`.

## Timing
- Step accepted at edge E. `output_spikes`, `membrane_out` and `spike_valid` update at E, so they are visible the cycle after the pulse.
- `spike_valid` is high exactly one cycle. `output_spikes` holds until the next accepted step or clear.
- Config write in the same cycle as an accepted step: the step evaluates with the old value; the new value is used from the next step.
- Back-to-back steps on consecutive cycles are supported at full rate. There is no pipeline bubble.
- `rst_n` low mid-operation: all state and config return to reset values at that edge.

## Test plan
- Reset: assert `rst_n=0` for 2 cycles with `step` toggling. Required: all outputs 0, `running=0`. Steps with run=0 produce no `spike_valid`.
- Delay: syn0 weight 7, delay 2; threshold 6; run. Drive `input_spikes=0x01` on step 1 only. Required: `output_spikes[0]=1` only after step 3; steps 1 and 2 give spike 0 and v=0.
- Leak/integrate: syn0 weight 2, delay 0; decay 1; threshold 5. Hold input 0x01. Required: v=1,2,3,4, then spike on step 5 with v=0.
- Refractory: same setup with refractory 2. Required: after the spike, the next two steps give v=0 and no spike; integration resumes on the third (v=1).
- Saturation: all 8 neuron-0 synapses weight -8 with input 0xFF gives v stays 0. All 8 synapses weight +7 with threshold 63 (sum 56) gives v=56 at step 1, then clamps to 63 and spikes at step 2.
- Collision: a config write changing syn0's weight on the step cycle uses the old weight for that step. Clear issued together with a step wins: v, hist and `output_spikes` become 0 and there is no `spike_valid`.
